// File: rtl/serial_fsm_pkg.sv
// Shared definitions for the serial detector/transmitter block family.
package serial_fsm_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'b00,
      ST_SHIFT = 2'b01,
      ST_GAP   = 2'b10
   } state_t;

   // Level held on the serial line whenever no frame bit is being sent.
   localparam logic IDLE_LEVEL = 1'b1;

   // Counter width able to hold 0..n-1, never narrower than one bit.
   function automatic int cnt_w(input int n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/load_down_counter.sv
// Loadable down-counter that saturates at zero; load takes priority over decrement.
module load_down_counter #(
   parameter int W = 4
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         load,
   input  logic [W-1:0] load_val,
   input  logic         dec,
   output logic [W-1:0] cnt,
   output logic         zero
);

   logic [W-1:0] r_cnt;

   // Count register: reload, or step down until zero is reached.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_cnt <= '0;
      end else if (load) begin
         r_cnt <= load_val;
      end else if (dec && (r_cnt != '0)) begin
         r_cnt <= r_cnt - W'(1);
      end
   end

   assign cnt  = r_cnt;
   assign zero = (r_cnt == '0);

endmodule

// File: rtl/serial_pattern_tx.sv
// Serial pattern transmitter: captures a word on valid/ready and sends it MSB-first,
// followed by a fixed run of idle bits. All serial outputs come straight from flops.
module serial_pattern_tx
   import serial_fsm_pkg::*;
#(
   parameter int   WIDTH    = 8,
   parameter int   GAP      = 2,
   parameter logic IDLE_BIT = IDLE_LEVEL
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] din,
   input  logic             din_valid,
   output logic             din_ready,
   output logic             x,
   output logic             x_valid,
   output logic             done,
   output logic             busy
);

   localparam int             BW      = cnt_w(WIDTH);
   localparam int             GW      = cnt_w(GAP + 1);
   localparam logic [BW-1:0]  BIT_LD  = BW'(WIDTH - 1);
   localparam logic [GW-1:0]  GAP_LD  = GW'((GAP > 0) ? GAP - 1 : 0);
   localparam bit             HAS_GAP = (GAP > 0);

   state_t           r_state;
   state_t           w_nxt_state;
   logic [WIDTH-1:0] r_sreg;
   logic [WIDTH-1:0] w_nxt_sreg;
   logic             r_x;
   logic             r_x_valid;
   logic             r_done;
   logic             w_nxt_x;
   logic             w_nxt_x_valid;
   logic             w_nxt_done;
   logic             w_ready;
   logic             w_xfer;
   logic             w_load;
   logic             w_bit_dec;
   logic             w_gap_load;
   logic             w_gap_dec;
   logic [BW-1:0]    w_bit_cnt;
   logic             w_bit_zero;
   logic [GW-1:0]    w_gap_cnt;
   logic             w_gap_zero;

   load_down_counter #(.W(BW)) u_bit_cnt (
      .clk      (clk),
      .rst      (rst),
      .load     (w_load),
      .load_val (BIT_LD),
      .dec      (w_bit_dec),
      .cnt      (w_bit_cnt),
      .zero     (w_bit_zero)
   );

   load_down_counter #(.W(GW)) u_gap_cnt (
      .clk      (clk),
      .rst      (rst),
      .load     (w_gap_load),
      .load_val (GAP_LD),
      .dec      (w_gap_dec),
      .cnt      (w_gap_cnt),
      .zero     (w_gap_zero)
   );

   // Ready in IDLE, on the final gap bit, or on the final frame bit when there is no gap,
   // so back-to-back frames keep a period of exactly WIDTH+GAP clocks.
   assign w_ready = (r_state == ST_IDLE) ||
                    ((r_state == ST_GAP) && (w_gap_cnt == '0)) ||
                    ((r_state == ST_SHIFT) && w_bit_zero && !HAS_GAP);
   assign w_xfer  = din_valid && w_ready;

   // Next-state, shift-register and registered-output logic.
   always_comb begin
      w_nxt_state   = r_state;
      w_nxt_sreg    = r_sreg;
      w_load        = 1'b0;
      w_bit_dec     = 1'b0;
      w_gap_load    = 1'b0;
      w_gap_dec     = 1'b0;
      w_nxt_x       = IDLE_BIT;
      w_nxt_x_valid = 1'b0;
      w_nxt_done    = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (w_xfer) w_load = 1'b1;
         end
         ST_SHIFT: begin
            w_bit_dec  = 1'b1;
            w_nxt_sreg = r_sreg << 1;
            if (w_bit_zero) begin
               if (HAS_GAP) begin
                  w_gap_load  = 1'b1;
                  w_nxt_state = ST_GAP;
               end else if (w_xfer) begin
                  w_load = 1'b1;
               end else begin
                  w_nxt_state = ST_IDLE;
               end
            end
         end
         ST_GAP: begin
            w_gap_dec = 1'b1;
            if (w_gap_zero) begin
               if (w_xfer) w_load = 1'b1;
               else        w_nxt_state = ST_IDLE;
            end
         end
         default: begin
            w_nxt_state = ST_IDLE;
         end
      endcase
      if (w_load) begin
         w_nxt_sreg  = din;
         w_nxt_state = ST_SHIFT;
      end
      // x leads the shift register by one clock so the MSB shows right after the handshake.
      if (w_load) begin
         w_nxt_x = din[WIDTH-1];
      end else if ((r_state == ST_SHIFT) && !w_bit_zero) begin
         w_nxt_x = r_sreg[WIDTH-2];
      end
      w_nxt_x_valid = (w_nxt_state == ST_SHIFT);
      w_nxt_done    = (r_state == ST_SHIFT) && (w_bit_cnt == BW'(1));
   end

   // State and serial output registers; reset drops the line to idle at once.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state   <= ST_IDLE;
         r_x       <= IDLE_BIT;
         r_x_valid <= 1'b0;
         r_done    <= 1'b0;
      end else begin
         r_state   <= w_nxt_state;
         r_x       <= w_nxt_x;
         r_x_valid <= w_nxt_x_valid;
         r_done    <= w_nxt_done;
      end
   end

   // Frame data register; its contents only matter after a load.
   always_ff @(posedge clk) begin
      r_sreg <= w_nxt_sreg;
   end

   assign din_ready = w_ready;
   assign x         = r_x;
   assign x_valid   = r_x_valid;
   assign done      = r_done;
   assign busy      = (r_state != ST_IDLE);

endmodule
